// File: rtl/data_valid.sv
// Serial frame receiver: hunts for an 8-bit header, collects a 32-bit body and
// publishes the 40-bit frame with a one-cycle valid pulse when the checksum matches.
module data_valid #(
  parameter logic [7:0] HEADER = 8'b1100_1100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ser_i,
  input  logic        sync_flag,
  output logic        header_flag,
  output logic        valid_flag,
  output logic [39:0] valid_data_o,
  output logic        dbg_state
);

  typedef enum logic {HUNT = 1'b0, BODY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [39:0] shift_q, shift_d;
  logic [3:0]  hunt_cnt_q, hunt_cnt_d;
  logic [4:0]  body_cnt_q, body_cnt_d;
  logic        header_flag_d;
  logic        valid_flag_d;
  logic [39:0] valid_data_d;

  logic [39:0] shifted;
  logic [7:0]  frame_sum;
  logic [3:0]  hunt_inc;

  assign shifted   = {shift_q[38:0], ser_i};
  assign frame_sum = shifted[39:32] + shifted[31:24] + shifted[23:16] + shifted[15:8];
  assign hunt_inc  = (hunt_cnt_q == 4'd8) ? 4'd8 : hunt_cnt_q + 4'd1;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= HUNT;
      shift_q      <= '0;
      hunt_cnt_q   <= '0;
      body_cnt_q   <= '0;
      header_flag  <= 1'b0;
      valid_flag   <= 1'b0;
      valid_data_o <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hunt_cnt_q   <= hunt_cnt_d;
      body_cnt_q   <= body_cnt_d;
      header_flag  <= header_flag_d;
      valid_flag   <= valid_flag_d;
      valid_data_o <= valid_data_d;
    end
  end

  // header_flag stays high through the cycle carrying the valid pulse, so it
  // is driven in every BODY cycle including the one accepting the last bit.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    hunt_cnt_d    = hunt_cnt_q;
    body_cnt_d    = body_cnt_q;
    header_flag_d = 1'b0;
    valid_flag_d  = 1'b0;
    valid_data_d  = valid_data_o;
    case (state_q)
      HUNT: begin
        if (sync_flag) begin
          shift_d    = shifted;
          hunt_cnt_d = hunt_inc;
          if (shifted[7:0] == HEADER && hunt_inc == 4'd8) begin
            state_d       = BODY;
            body_cnt_d    = '0;
            header_flag_d = 1'b1;
          end
        end
      end
      BODY: begin
        header_flag_d = 1'b1;
        if (sync_flag) begin
          shift_d = shifted;
          if (body_cnt_q == 5'd31) begin
            // Counter restart keeps body bits from being re-scanned as a header.
            state_d    = HUNT;
            hunt_cnt_d = '0;
            body_cnt_d = '0;
            if (frame_sum == shifted[7:0]) begin
              valid_flag_d = 1'b1;
              valid_data_d = shifted;
            end
          end else begin
            body_cnt_d = body_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_data_valid.sv
// Bench for data_valid: frames are driven bit-serially; expected frames are
// queued on send and compared whenever valid_flag pulses.
module tb_data_valid;

  localparam logic [39:0] F_GOOD  = 40'hCC_17_18_19_14;
  localparam logic [39:0] F_BAD   = 40'hCC_17_18_19_15;
  localparam logic [39:0] F_CD    = 40'hCD_00_00_00_00;
  localparam logic [39:0] F_GOOD2 = 40'hCC_01_02_03_D2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_i;
  logic        sync_flag;
  logic        header_flag;
  logic        valid_flag;
  logic [39:0] valid_data_o;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cyc[$];
  logic [39:0] exp_q[$];

  data_valid dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_i        (ser_i),
    .sync_flag    (sync_flag),
    .header_flag  (header_flag),
    .valid_flag   (valid_flag),
    .valid_data_o (valid_data_o),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    cyc++;
    if (valid_flag === 1'b1) begin
      pulse_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got data %h, required no pulse", valid_data_o);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if (valid_data_o !== e) begin
          n_err++;
          $display("FAIL pulse_data: got %h, required %h", valid_data_o, e);
        end
      end
    end
  end

  function automatic logic [39:0] mk_frame(input logic [7:0] h, input logic [23:0] d);
    logic [7:0] cs;
    cs = h + d[23:16] + d[15:8] + d[7:0];
    return {h, d, cs};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b1;
    idle(n);
    rst_n = 1'b0;
  endtask

  // Sends the first nbits of f MSB first; gaps are idle cycles between strobes.
  task automatic send_frame(input logic [39:0] f, input int nbits, input int gmin,
                            input int gmax, input bit toggle,
                            output logic hf7, output logic hf8, output logic vf40,
                            output logic hf40, output logic vf41, output logic hf41,
                            output logic hf_any);
    int gap;
    hf7 = 1'bx; hf8 = 1'bx; vf40 = 1'bx; hf40 = 1'bx; vf41 = 1'bx; hf41 = 1'bx;
    hf_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sync_flag = 1'b1;
      ser_i = f[39-i];
      @(posedge clk); #1;
      sync_flag = 1'b0;
      if (header_flag === 1'b1) hf_any = 1'b1;
      if (i == 6) hf7 = header_flag;
      if (i == 7) hf8 = header_flag;
      if (i == 39) begin
        vf40 = valid_flag;
        hf40 = header_flag;
      end
      gap = $urandom_range(gmax, gmin);
      for (int g = 1; g < gap; g++) begin
        if (toggle) ser_i = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        if (header_flag === 1'b1) hf_any = 1'b1;
        if (i == 39 && g == 1) begin
          vf41 = valid_flag;
          hf41 = header_flag;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; ser_i = 1'b0; sync_flag = 1'b0;
    idle(3);
    rst_n = 1'b0;
    n_cmp++;
    if (valid_flag !== 1'b0 || header_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got vf=%b hf=%b, required 0 0", valid_flag, header_flag);
    end
    n_cmp++;
    if (valid_data_o !== 40'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 0", valid_data_o);
    end
    n_cmp++;
    if (dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b, required 0 (HUNT)", dbg_state);
    end
  endtask

  task automatic check_good_timing(input string name, input logic hf7, input logic hf8,
                                   input logic vf40, input logic hf40, input logic vf41,
                                   input logic hf41);
    n_cmp++;
    if (hf7 !== 1'b0 || hf8 !== 1'b1) begin
      n_err++;
      $display("FAIL %s_header_rise: got after7=%b after8=%b, required 0 1", name, hf7, hf8);
    end
    n_cmp++;
    if (vf40 !== 1'b1 || hf40 !== 1'b1) begin
      n_err++;
      $display("FAIL %s_last_bit: got vf=%b hf=%b, required 1 1", name, vf40, hf40);
    end
    n_cmp++;
    if (vf41 !== 1'b0 || hf41 !== 1'b0) begin
      n_err++;
      $display("FAIL %s_after_pulse: got vf=%b hf=%b, required 0 0", name, vf41, hf41);
    end
  endtask

  task automatic test_valid_frame;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    exp_q.push_back(F_GOOD);
    send_frame(F_GOOD, 40, 5, 5, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(2);
    check_good_timing("valid", hf7, hf8, vf40, hf40, vf41, hf41);
    n_cmp++;
    if (pulse_cyc.size() - p0 != 1) begin
      n_err++;
      $display("FAIL valid_pulse_count: got %0d, required 1", pulse_cyc.size() - p0);
    end
    n_cmp++;
    if (valid_data_o !== F_GOOD) begin
      n_err++;
      $display("FAIL valid_data_hold: got %h, required %h", valid_data_o, F_GOOD);
    end
  endtask

  task automatic test_bad_checksum;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    send_frame(F_BAD, 40, 5, 5, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(2);
    n_cmp++;
    if (hf8 !== 1'b1 || hf40 !== 1'b1) begin
      n_err++;
      $display("FAIL bad_header_flag: got after8=%b last=%b, required 1 1", hf8, hf40);
    end
    n_cmp++;
    if (vf40 !== 1'b0 || pulse_cyc.size() != p0) begin
      n_err++;
      $display("FAIL bad_no_pulse: got vf=%b pulses=%0d, required 0 0", vf40, pulse_cyc.size() - p0);
    end
    n_cmp++;
    if (valid_data_o !== 40'h0 || header_flag !== 1'b0) begin
      n_err++;
      $display("FAIL bad_data: got %h hf=%b, required 0 0", valid_data_o, header_flag);
    end
  endtask

  task automatic test_wrong_header;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    send_frame(F_CD, 40, 1, 3, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(2);
    n_cmp++;
    if (hfa !== 1'b0 || pulse_cyc.size() != p0) begin
      n_err++;
      $display("FAIL wrong_header: got hf_seen=%b pulses=%0d, required 0 0", hfa, pulse_cyc.size() - p0);
    end
  endtask

  task automatic test_gap_toggle;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    exp_q.push_back(F_GOOD);
    send_frame(F_GOOD, 40, 2, 9, 1'b1, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(2);
    check_good_timing("gap", hf7, hf8, vf40, hf40, vf41, hf41);
    n_cmp++;
    if (pulse_cyc.size() - p0 != 1 || valid_data_o !== F_GOOD) begin
      n_err++;
      $display("FAIL gap_result: got pulses=%0d data=%h, required 1 %h", pulse_cyc.size() - p0, valid_data_o, F_GOOD);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    send_frame(F_GOOD, 20, 5, 5, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    n_cmp++;
    if (hf8 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_header: got %b, required 1", hf8);
    end
    do_reset(1);
    n_cmp++;
    if (header_flag !== 1'b0 || dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abandon: got hf=%b state=%b, required 0 0", header_flag, dbg_state);
    end
    exp_q.push_back(F_GOOD);
    send_frame(F_GOOD, 40, 5, 5, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(2);
    check_good_timing("resent", hf7, hf8, vf40, hf40, vf41, hf41);
    n_cmp++;
    if (pulse_cyc.size() - p0 != 1 || valid_data_o !== F_GOOD) begin
      n_err++;
      $display("FAIL mid_result: got pulses=%0d data=%h, required 1 %h", pulse_cyc.size() - p0, valid_data_o, F_GOOD);
    end
  endtask

  task automatic test_back_to_back;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    int p0;
    do_reset(1);
    p0 = pulse_cyc.size();
    exp_q.push_back(F_GOOD);
    exp_q.push_back(F_GOOD2);
    send_frame(F_GOOD, 40, 1, 1, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    n_cmp++;
    if (vf40 !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_pulse: got %b, required 1", vf40);
    end
    send_frame(F_GOOD2, 40, 1, 1, 1'b0, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
    idle(3);
    n_cmp++;
    if (pulse_cyc.size() - p0 != 2) begin
      n_err++;
      $display("FAIL b2b_pulse_count: got %0d, required 2", pulse_cyc.size() - p0);
    end else begin
      n_cmp++;
      if (pulse_cyc[p0+1] - pulse_cyc[p0] != 40) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d, required 40", pulse_cyc[p0+1] - pulse_cyc[p0]);
      end
    end
    n_cmp++;
    if (valid_data_o !== F_GOOD2) begin
      n_err++;
      $display("FAIL b2b_data: got %h, required %h", valid_data_o, F_GOOD2);
    end
  endtask

  // Random bodies, some with corrupted checksums; output must hold the last good frame.
  task automatic test_random_frames;
    logic hf7, hf8, vf40, hf40, vf41, hf41, hfa;
    logic [39:0] f, last_good;
    do_reset(1);
    last_good = '0;
    for (int k = 0; k < 8; k++) begin
      f = mk_frame(8'hCC, 24'($urandom()));
      if ($urandom_range(2, 0) == 0) f[7:0] = f[7:0] ^ 8'($urandom_range(255, 1));
      else begin
        exp_q.push_back(f);
        last_good = f;
      end
      send_frame(f, 40, 1, 3, 1'b1, hf7, hf8, vf40, hf40, vf41, hf41, hfa);
      idle(2);
      n_cmp++;
      if (valid_data_o !== last_good) begin
        n_err++;
        $display("FAIL rand_hold_%0d: got %h, required %h", k, valid_data_o, last_good);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_valid_frame();
    test_wrong_header();
    test_gap_toggle();
    test_reset_mid_frame();
    test_back_to_back();
    test_random_frames();
    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_pulses: got %0d frames never published, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
